// File: rtl/dev_uart_if.sv
// Crossbar device port for the UART window: single-cycle write strobe plus
// combinational read data.
interface dev_uart_if;
    logic [15:0] dev_addr;
    logic [15:0] dev_wdata;
    logic        dev_wen;
    logic [15:0] dev_rdata;

    modport master (output dev_addr, output dev_wdata, output dev_wen, input dev_rdata);
    modport slave  (input dev_addr, input dev_wdata, input dev_wen, output dev_rdata);
endinterface

// File: rtl/dev_uart.sv
// Memory-mapped 8N1 UART: TX/RX byte FIFOs, sticky error flags and a programmable
// baud divisor behind the crossbar's single-cycle device port.

module dev_uart_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // Full is judged on the pre-pop count: a push into a full FIFO is dropped
    // even if a pop happens in the same cycle.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module dev_uart #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic      clk,
    input  logic      rst_n,
    dev_uart_if.slave bus,
    output logic      txd,
    input  logic      rxd,
    output logic      irq
);
    localparam logic [15:0] ADDR_TXDATA  = 16'h7000;
    localparam logic [15:0] ADDR_RXDATA  = 16'h7001;
    localparam logic [15:0] ADDR_STATUS  = 16'h7002;
    localparam logic [15:0] ADDR_BAUDDIV = 16'h7003;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic        wr_tx, wr_rx, wr_st, wr_bd;
    logic [15:0] div, bit_last, half_last, rdata;
    logic        tx_ovf, rx_ovr, rx_frm, tx_busy;
    logic        tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_head, rx_head;
    logic        rx_push, rx_empty, rx_full, rx_ovr_set, rx_frm_set;

    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_bit, tx_bit_nxt;
    logic [7:0]  tx_sh, tx_sh_nxt;
    logic        tx_tick;

    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic [7:0]  rx_sh, rx_sh_nxt;
    logic        rx_tick;
    logic        rxd_p0, rxd_p1, rxd_p2;

    assign wr_tx = bus.dev_wen && (bus.dev_addr == ADDR_TXDATA);
    assign wr_rx = bus.dev_wen && (bus.dev_addr == ADDR_RXDATA);
    assign wr_st = bus.dev_wen && (bus.dev_addr == ADDR_STATUS);
    assign wr_bd = bus.dev_wen && (bus.dev_addr == ADDR_BAUDDIV);

    // Counters run from P-1 down to 0; P = max(div,3)+1, half point = floor(P/2).
    assign bit_last  = (div < 16'd3) ? 16'd3 : div;
    assign half_last = (bit_last >> 1) - {15'd0, ~bit_last[0]};

    dev_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_tx), .pop(tx_pop), .din(bus.dev_wdata[7:0]),
        .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    dev_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(wr_rx), .din(rx_sh),
        .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= DEFAULT_DIV;
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
            rx_frm <= 1'b0;
        end else begin
            if (wr_bd) div <= bus.dev_wdata;
            tx_ovf <= (wr_tx && tx_full) || (tx_ovf && !(wr_st && bus.dev_wdata[5]));
            rx_ovr <= rx_ovr_set || (rx_ovr && !(wr_st && bus.dev_wdata[6]));
            rx_frm <= rx_frm_set || (rx_frm && !(wr_st && bus.dev_wdata[7]));
        end
    end

    // ---------------- TX engine ----------------
    assign tx_tick = (tx_cnt == 16'd0);
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
        end
    end

    always_ff @(posedge clk) tx_sh <= tx_sh_nxt;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        tx_pop       = 1'b0;
        if (tx_state != TX_IDLE)
            tx_cnt_nxt = tx_tick ? bit_last : tx_cnt - 16'd1;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_pop       = 1'b1;
                tx_sh_nxt    = tx_head;
                tx_cnt_nxt   = bit_last;
                tx_state_nxt = TX_START;
            end
            TX_START: if (tx_tick) begin
                tx_bit_nxt   = 3'd0;
                tx_state_nxt = TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
                tx_sh_nxt  = {1'b0, tx_sh[7:1]};
                tx_bit_nxt = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            end
            TX_STOP: if (tx_tick) begin
                // Chain straight into the next frame when data is waiting.
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_sh_nxt    = tx_head;
                    tx_state_nxt = TX_START;
                end else begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    assign txd = (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

    // ---------------- RX synchronizer / engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_p0   <= 1'b1;
            rxd_p1   <= 1'b1;
            rxd_p2   <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rxd_p0   <= rxd;
            rxd_p1   <= rxd_p0;
            rxd_p2   <= rxd_p1;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    always_ff @(posedge clk) rx_sh <= rx_sh_nxt;

    assign rx_tick = (rx_cnt == 16'd0);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_push      = 1'b0;
        rx_ovr_set   = 1'b0;
        rx_frm_set   = 1'b0;
        if (rx_state == RX_START || rx_state == RX_DATA || rx_state == RX_STOP)
            rx_cnt_nxt = rx_tick ? bit_last : rx_cnt - 16'd1;
        case (rx_state)
            RX_IDLE: if (rxd_p2 && !rxd_p1) begin
                rx_cnt_nxt   = half_last;
                rx_state_nxt = RX_START;
            end
            RX_START: if (rx_tick) begin
                rx_bit_nxt   = 3'd0;
                rx_state_nxt = rxd_p1 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_sh_nxt  = {rxd_p1, rx_sh[7:1]};
                rx_bit_nxt = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                if (!rxd_p1) begin
                    rx_frm_set   = 1'b1;
                    rx_state_nxt = RX_WAIT;
                end else begin
                    rx_ovr_set   = rx_full;
                    rx_push      = !rx_full;
                    rx_state_nxt = RX_IDLE;
                end
            end
            RX_WAIT: if (rxd_p1) rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- Read mux / interrupt ----------------
    always_comb begin
        rdata = 16'h0000;
        case (bus.dev_addr)
            ADDR_RXDATA:  rdata = {7'b0, !rx_empty, rx_empty ? 8'h00 : rx_head};
            ADDR_STATUS:  rdata = {8'h00, rx_frm, rx_ovr, tx_ovf, tx_busy,
                                   rx_full, rx_empty, tx_empty, tx_full};
            ADDR_BAUDDIV: rdata = div;
            default:      rdata = 16'h0000;
        endcase
    end

    assign bus.dev_rdata = rdata;
    assign irq = !rx_empty || tx_ovf || rx_ovr || rx_frm;
endmodule
